cpu_environment: RTL and testbench
==================================

CPU_ENVIRONMENT -- requirements
Module: cpu_environment

Interface
REQ-001 Parameter MEM_WORDS, default 262144, meaning the number of usable external SRAM words (2..262144).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 switches  input  10  sample value to log.
REQ-005 buttons  input  4  active-high push buttons: [0] log, [1] play, [2] clear, [3] unused.
REQ-006 led_r  output  10  last value played back.
REQ-007 led_g  output  8  status: [7] full, [6] empty, [5:0] stored-word count bits [5:0].
REQ-008 addresses  output  18  SRAM word address.
REQ-009 control_mem  output  5  SRAM strobes, all active-low, ordered {ce_n, oe_n, we_n, ub_n, lb_n}.
REQ-010 data  inout  16  SRAM data bus; high-Z except during a write cycle.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a rising-edge detector; the result is a one-clock pulse. A held button produces exactly one pulse.
REQ-012 Control FSM states: IDLE, WRITE, READ. WRITE and READ last exactly one clock, then return to IDLE.
REQ-013 Pulses are accepted only in IDLE; pulses arriving in WRITE or READ are dropped.
REQ-014 Priority for simultaneous pulses: clear > log > play.
REQ-015 Clear pulse: wp and rp are set to 0 and count to 0 in one clock, with no SRAM cycle; led_r is unchanged.
REQ-016 Log pulse, when not full: go to WRITE.
  - Drive addresses = wp, data = {6'b0, switches} (captured at the pulse), control_mem = 5'b01000.
  - Then wp increments modulo MEM_WORDS and count increments.
REQ-017 Play pulse, when not empty: go to READ.
  - Drive addresses = rp, control_mem = 5'b00100, data bus undriven.
  - At the end of the cycle, led_r captures data[9:0]; then rp increments modulo MEM_WORDS and count decrements.
REQ-018 In IDLE: control_mem = 5'b11100, addresses = wp, data = high-Z.
REQ-019 Full is count == MEM_WORDS; empty is count == 0. Play when empty is ignored (no SRAM cycle, led_r holds).
REQ-020 Latency: a button sampled high at edge N, low at edge N-1, gives a strobe cycle starting at edge N+3.
REQ-021 count is 19 bits wide; led_g[5:0] = count[5:0].

Reset
REQ-022 When reset is high at a clock edge:
  - FSM returns to IDLE; wp, rp and count = 0; synchronizers and edge detectors are cleared.
  - led_r = 0, led_g = 8'b01000000, control_mem = 5'b11100, addresses = 0, data = high-Z.
REQ-023 Reset asserted during WRITE or READ aborts the cycle; pointers do not advance.

Configuration
REQ-024 With macro OVERFLOW_WRAP_EN defined, a log when full still writes at wp.
  - wp advances modulo MEM_WORDS and rp advances with it, discarding the oldest word.
  - count stays MEM_WORDS.
REQ-025 Without OVERFLOW_WRAP_EN, a log when full is ignored (no SRAM cycle).

Structure
REQ-026 A shared package cpu_env_pkg holds the FSM state enum and the control_mem constants CTRL_IDLE=5'b11100, CTRL_WRITE=5'b01000, CTRL_READ=5'b00100.
REQ-027 One sub-module button_edge (2-flop synchronizer plus rising-edge pulse) is instantiated once per button bit.

Verification
REQ-028 Reset check: hold reset 1 clock -> led_r=0, led_g=8'h40, control_mem=5'b11100, data high-Z, addresses=0.
REQ-029 Log: switches=10'h2A5, pulse buttons[0] for 3 clocks -> exactly one cycle with addresses=0, data=16'h02A5, control_mem=5'b01000, then led_g=8'h01.
REQ-030 Playback:
  - Log 10'h2A5 then 10'h013, then press buttons[1] twice.
  - Expected: reads at addresses 0 then 1, control_mem=5'b00100; led_r=10'h2A5 then 10'h013; led_g=8'h40.
  - A third play issues no SRAM cycle.
REQ-031 Simultaneous: press buttons[0] and buttons[2] together after 2 logs -> no SRAM cycle, count 0, led_g=8'h40.
REQ-032 Full, with MEM_WORDS=4:
  - After 4 logs, led_g=8'h84.
  - 5th log: no write without OVERFLOW_WRAP_EN; with it, a write at address 0 and the next play reads address 1.
REQ-033 Reset during WRITE -> control_mem=5'b11100 next cycle, led_g=8'h40.

Source files
------------

// File: rtl/cpu_env_pkg.sv
// Shared types and constants for the switch-logging SRAM environment.
// SRAM strobe words are ordered {ce_n, oe_n, we_n, ub_n, lb_n}, all active-low.
package cpu_env_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [4:0] CTRL_IDLE  = 5'b11100;
  localparam logic [4:0] CTRL_WRITE = 5'b01000;
  localparam logic [4:0] CTRL_READ  = 5'b00100;

  localparam int ADDR_W = 18;
  localparam int CNT_W  = 19;

  // Circular pointer advance; last is the highest usable word index.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p,
                                                 input logic [CNT_W-1:0]  last);
    return ({1'b0, p} == last) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/cpu_environment_button_edge.sv
// Button conditioner: 2-flop synchronizer, then a registered rising-edge pulse.
// A held button yields exactly one single-clock pulse, two clocks after first sample.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q, pulse_q;
  logic pulse_d;

  assign pulse_d = sync_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_environment.sv
// Logs switch values into an external SRAM FIFO and plays them back onto LEDs.
// Optional macro OVERFLOW_WRAP_EN: a log when full overwrites the oldest word.
module cpu_environment
  import cpu_env_pkg::*;
#(
  parameter int MEM_WORDS = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  switches,
  input  logic [3:0]  buttons,
  output logic [9:0]  led_r,
  output logic [7:0]  led_g,
  output logic [17:0] addresses,
  output logic [4:0]  control_mem,
  inout  wire  [15:0] data
);

  localparam logic [CNT_W-1:0] WORDS = CNT_W'(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_WORDS - 1);

  logic [3:0] pulse;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_edge u_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (buttons[i]),
      .pulse_o (pulse[i])
    );
  end

  state_t              state_q;
  logic [ADDR_W-1:0]   wp_q, rp_q, addr_q;
  logic [CNT_W-1:0]    count_q;
  logic [9:0]          led_r_q;
  logic [4:0]          ctrl_q;
  logic [15:0]         wdat_q;
  logic                drive_q;
  logic                full, empty, log_ok;
  logic                unused_bits;

  assign full  = (count_q == WORDS);
  assign empty = (count_q == '0);

`ifdef OVERFLOW_WRAP_EN
  assign log_ok = 1'b1;
`else
  assign log_ok = ~full;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      addr_q  <= '0;
      led_r_q <= '0;
      ctrl_q  <= CTRL_IDLE;
      wdat_q  <= '0;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_q <= wp_q;
          if (pulse[2]) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            addr_q  <= '0;
          end else if (pulse[0]) begin
            // A log pulse outranks play even when the log itself is refused.
            if (log_ok) begin
              state_q <= ST_WRITE;
              ctrl_q  <= CTRL_WRITE;
              wdat_q  <= {6'b0, switches};
              drive_q <= 1'b1;
            end
          end else if (pulse[1] && !empty) begin
            state_q <= ST_READ;
            ctrl_q  <= CTRL_READ;
            addr_q  <= rp_q;
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          ctrl_q  <= CTRL_IDLE;
          drive_q <= 1'b0;
          wp_q    <= ptr_next(wp_q, LAST);
          addr_q  <= ptr_next(wp_q, LAST);
          // Only reachable when full with wrap enabled: drop the oldest word.
          if (full) rp_q <= ptr_next(rp_q, LAST);
          else      count_q <= count_q + 1'b1;
        end
        ST_READ: begin
          state_q <= ST_IDLE;
          ctrl_q  <= CTRL_IDLE;
          led_r_q <= data[9:0];
          rp_q    <= ptr_next(rp_q, LAST);
          count_q <= count_q - 1'b1;
          addr_q  <= wp_q;
        end
        default: begin
          state_q <= ST_IDLE;
          ctrl_q  <= CTRL_IDLE;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign led_r       = led_r_q;
  assign led_g       = {full, empty, count_q[5:0]};
  assign addresses   = addr_q;
  assign control_mem = ctrl_q;
  assign data        = drive_q ? wdat_q : 16'bz;

  assign unused_bits = ^{pulse[3], data[15:10]};

endmodule

// File: tb/tb_cpu_environment.sv
// Bench for cpu_environment with a 4-word SRAM model on the shared data bus.
module tb_cpu_environment;
  import cpu_env_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  switches;
  logic [3:0]  buttons;
  logic [9:0]  led_r;
  logic [7:0]  led_g;
  logic [17:0] addresses;
  logic [4:0]  control_mem;
  wire  [15:0] data;

  logic [15:0] sram [0:3];

  cpu_environment #(.MEM_WORDS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .switches    (switches),
    .buttons     (buttons),
    .led_r       (led_r),
    .led_g       (led_g),
    .addresses   (addresses),
    .control_mem (control_mem),
    .data        (data)
  );

  initial forever #5 clk = ~clk;

  // Released bus floats high, so all-ones marks "nobody driving".
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (data[g]);
  end

  assign data = (!control_mem[4] && !control_mem[3]) ? sram[addresses[1:0]] : 16'bz;

  always @(posedge clk)
    if (!control_mem[4] && !control_mem[2]) sram[addresses[1:0]] <= data;

  typedef struct {
    logic [3:0]  btn;
    logic [9:0]  sw;
    logic        cyc;
    logic [4:0]  ctrl;
    logic [17:0] addr;
    logic [15:0] dat;
    logic [9:0]  lr;
    logic [7:0]  lg;
  } vec_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [17:0] addr;
    logic [15:0] dat;
  } cyc_t;

  vec_t vecs[$];
  cyc_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [3:0] b, input logic [9:0] sw, input logic cyc,
                               input logic [4:0] ctrl, input logic [17:0] addr,
                               input logic [9:0] lr, input logic [7:0] lg);
    vec_t v;
    v.btn = b; v.sw = sw; v.cyc = cyc; v.ctrl = ctrl; v.addr = addr;
    v.dat = (ctrl == CTRL_WRITE) ? {6'b0, sw} : 16'h0000;
    v.lr = lr; v.lg = lg;
    return v;
  endfunction

  task automatic push_exp(input logic [4:0] ctrl, input logic [17:0] addr, input logic [15:0] dat);
    cyc_t c;
    c.ctrl = ctrl; c.addr = addr; c.dat = dat;
    exp_q.push_back(c);
  endtask

  // Hold buttons for 3 clocks, watch 10 clocks, score every strobe cycle seen.
  task automatic press(input logic [3:0] b, input logic [9:0] sw,
                       output int nstrobe, output int first);
    switches = sw;
    buttons  = b;
    nstrobe  = 0;
    first    = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3) buttons = 4'b0000;
      if (control_mem != CTRL_IDLE) begin
        nstrobe++;
        if (first == 0) first = i;
        if (exp_q.size() == 0) chk("unexpected_cycle", control_mem, CTRL_IDLE);
        else begin
          cyc_t e;
          e = exp_q.pop_front();
          chk("strobe_ctrl", control_mem, e.ctrl);
          chk("strobe_addr", addresses, e.addr);
          if (e.ctrl == CTRL_WRITE) chk("strobe_data", data, e.dat);
        end
      end
    end
    exp_q.delete();
  endtask

  localparam logic [9:0] LR_AFTER =
`ifdef OVERFLOW_WRAP_EN
    10'h0BB;
`else
    10'h0AA;
`endif

  initial begin
    int ns, fs, n;
    logic found;

    vecs.push_back(mkv(4'b0001, 10'h2A5, 1, CTRL_WRITE, 18'd0, 10'h000, 8'h01));
    vecs.push_back(mkv(4'b0001, 10'h013, 1, CTRL_WRITE, 18'd1, 10'h000, 8'h02));
    vecs.push_back(mkv(4'b0010, 10'h000, 1, CTRL_READ,  18'd0, 10'h2A5, 8'h01));
    vecs.push_back(mkv(4'b0010, 10'h000, 1, CTRL_READ,  18'd1, 10'h013, 8'h40));
    vecs.push_back(mkv(4'b0010, 10'h000, 0, CTRL_IDLE,  18'd0, 10'h013, 8'h40));
    vecs.push_back(mkv(4'b0001, 10'h111, 1, CTRL_WRITE, 18'd2, 10'h013, 8'h01));
    vecs.push_back(mkv(4'b0001, 10'h222, 1, CTRL_WRITE, 18'd3, 10'h013, 8'h02));
    vecs.push_back(mkv(4'b0101, 10'h333, 0, CTRL_IDLE,  18'd0, 10'h013, 8'h40));
    vecs.push_back(mkv(4'b0001, 10'h0AA, 1, CTRL_WRITE, 18'd0, 10'h013, 8'h01));
    vecs.push_back(mkv(4'b0001, 10'h0BB, 1, CTRL_WRITE, 18'd1, 10'h013, 8'h02));
    vecs.push_back(mkv(4'b0001, 10'h0CC, 1, CTRL_WRITE, 18'd2, 10'h013, 8'h03));
    vecs.push_back(mkv(4'b0001, 10'h0DD, 1, CTRL_WRITE, 18'd3, 10'h013, 8'h84));
`ifdef OVERFLOW_WRAP_EN
    vecs.push_back(mkv(4'b0001, 10'h3FF, 1, CTRL_WRITE, 18'd0, 10'h013, 8'h84));
    vecs.push_back(mkv(4'b0010, 10'h000, 1, CTRL_READ,  18'd1, 10'h0BB, 8'h03));
`else
    vecs.push_back(mkv(4'b0001, 10'h3FF, 0, CTRL_IDLE,  18'd0, 10'h013, 8'h84));
    vecs.push_back(mkv(4'b0010, 10'h000, 1, CTRL_READ,  18'd0, 10'h0AA, 8'h03));
`endif
    vecs.push_back(mkv(4'b0100, 10'h000, 0, CTRL_IDLE,  18'd0, LR_AFTER, 8'h40));
    vecs.push_back(mkv(4'b0011, 10'h155, 1, CTRL_WRITE, 18'd0, LR_AFTER, 8'h01));
    vecs.push_back(mkv(4'b0100, 10'h000, 0, CTRL_IDLE,  18'd0, LR_AFTER, 8'h40));

    reset = 1'b1; buttons = 4'b0000; switches = 10'h000;
    step();
    reset = 1'b0;
    chk("rst_led_r", led_r, 10'h000);
    chk("rst_led_g", led_g, 8'h40);
    chk("rst_ctrl",  control_mem, CTRL_IDLE);
    chk("rst_addr",  addresses, 18'd0);
    chk("rst_data_hiz", data, 16'hFFFF);
    step();

    foreach (vecs[k]) begin
      if (vecs[k].cyc) push_exp(vecs[k].ctrl, vecs[k].addr, vecs[k].dat);
      press(vecs[k].btn, vecs[k].sw, ns, fs);
      chk($sformatf("v%0d_strobes", k), ns, 32'(vecs[k].cyc));
      if (vecs[k].cyc) chk($sformatf("v%0d_latency", k), fs, 4);
      chk($sformatf("v%0d_led_r", k), led_r, vecs[k].lr);
      chk($sformatf("v%0d_led_g", k), led_g, vecs[k].lg);
      chk($sformatf("v%0d_data_hiz", k), data, 16'hFFFF);
    end

    // Reset landing inside a WRITE cycle aborts it.
    switches = 10'h066; buttons = 4'b0001; found = 1'b0; n = 0;
    while (!found && n < 10) begin
      step();
      n++;
      if (n == 3) buttons = 4'b0000;
      if (control_mem == CTRL_WRITE) found = 1'b1;
    end
    chk("rstwr_write_seen", found, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstwr_ctrl", control_mem, CTRL_IDLE);
    chk("rstwr_led_g", led_g, 8'h40);
    chk("rstwr_addr", addresses, 18'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rstwr_led_g_settled", led_g, 8'h40);

    push_exp(CTRL_WRITE, 18'd0, 16'h0077);
    press(4'b0001, 10'h077, ns, fs);
    chk("postrst_strobes", ns, 1);
    chk("postrst_led_g", led_g, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
